seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//   Serial framer/transmitter for the sequence-detector link. Accepts a parallel
//   payload word via valid/ready, then drives a serial bit stream: the sync
//   PATTERN (MSB first) followed by the payload (MSB first) and an idle gap.
//   Drives the 'a' input of the overlapping Moore 1010 detector on the far end.
// PARAMETERS
//   PAT_W    4        sync pattern length in bits (>=1)
//   PATTERN  4'b1010  sync pattern, PAT_W bits, sent MSB first
//   DATA_W   8        payload width in bits (>=1)
//   GAP_CYC  1        idle cycles (sout=0) after each frame (>=0)
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous, active-high reset
//   data_in     in   DATA_W  payload word, sampled on accept
//   data_valid  in   1       payload offered
//   data_ready  out  1       block can accept (high only in IDLE)
//   abort       in   1       sync abort of current frame
//   sout        out  1       serial bit (registered)
//   sout_valid  out  1       high while a preamble or payload bit is on sout
//   frame_done  out  1       1-cycle pulse during the last payload bit
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. All outputs registered.
// - Reset: state=IDLE, sout=0, sout_valid=0, frame_done=0, data_ready=1,
//   bit counter=0, shift reg=0. Reset mid-frame discards the frame; no further bits.
// - FSM states: IDLE, PRE, DATA, GAP.
//   IDLE: data_ready=1, sout=0, sout_valid=0. Accept = data_valid&&data_ready at
//     edge -> latch data_in into shift reg, go PRE, sout=PATTERN[PAT_W-1].
//     First preamble bit is on sout the cycle immediately after the accept edge.
//   PRE: PAT_W cycles, sout=PATTERN[PAT_W-1..0] in order, sout_valid=1. After
//     the bit PATTERN[0] -> DATA.
//   DATA: DATA_W cycles, sout=payload[DATA_W-1..0] in order, sout_valid=1;
//     frame_done=1 only in the cycle carrying payload[0]. Then -> GAP if
//     GAP_CYC>0, else -> IDLE.
//   GAP: GAP_CYC cycles, sout=0, sout_valid=0, data_ready=0; then -> IDLE.
// - Frame = PAT_W+DATA_W valid cycles. Min accept-to-accept period with
//   data_valid held high = PAT_W+DATA_W+GAP_CYC+1 cycles (one IDLE cycle).
// - data_in/data_valid ignored outside IDLE; payload changes after accept
//   have no effect on the frame in flight.
// - abort: sampled at every edge; in PRE/DATA/GAP -> IDLE next edge, sout=0,
//   sout_valid=0, frame_done=0 (no done pulse for aborted frame). abort in IDLE
//   has priority over accept: no accept, stays IDLE. reset has priority over abort.
// - Bit counter width $clog2(max(PAT_W,DATA_W,GAP_CYC)+1); counts down, no wrap
//   beyond terminal value. Unused state encodings -> IDLE.
// - sout holds 0 whenever sout_valid=0 (line idles low; never forms a 1010 alone).
// TESTING
//   1 Reset held 3 cycles with data_valid=1 -> data_ready=1, sout=0,
//     sout_valid=0, frame_done=0; no accept while reset=1.
//   2 Defaults, data_in=8'hA5 pulsed 1 cycle -> next 12 cycles sout=
//     1,0,1,0,1,0,1,0,0,1,0,1, sout_valid=1; frame_done in cycle 12 only;
//     1 GAP cycle, then data_ready=1.
//   3 data_valid held high, data_in=8'h3C then 8'hC3 -> second preamble bit
//     starts exactly 14 cycles after the first; second frame carries 8'hC3.
//   4 abort asserted on 3rd payload bit -> sout=0, sout_valid=0 next cycle,
//     no frame_done, data_ready=1; next accepted frame is complete and correct.
//   5 reset asserted during 2nd preamble bit -> outputs at reset values next
//     cycle; abort+data_valid together in IDLE -> no accept.
//   6 Loopback into omoseq detector (a=sout), data_in=8'h00 -> detector y=1
//     exactly once per frame, the cycle after the 4th preamble bit.

Source files
------------

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_tx
//  Description : Serial framer/transmitter. Accepts a parallel payload word on
//                a valid/ready handshake and shifts out the sync pattern
//                (MSB first), then the payload (MSB first), then an idle gap.
//                The line idles low so it never forms a sync pattern by itself.
//  Revision    : 1.0  - initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int              DATA_W  = 8,
    parameter int              GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              abort,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_done
);

    // Counter is sized to hold the longest of the three phase lengths.
    localparam int c_MAX_A = (PAT_W > DATA_W) ? PAT_W : DATA_W;
    localparam int c_MAX   = (c_MAX_A > GAP_CYC) ? c_MAX_A : GAP_CYC;
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    // The counter holds the index of the bit currently on sout, so each
    // phase is loaded with (length - 1) and ends when it reaches zero.
    localparam logic [c_CNT_W-1:0] c_PRE_LOAD  = c_CNT_W'(PAT_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LOAD = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic               c_HAS_GAP   = (GAP_CYC > 0);
    localparam logic               c_ONE_BIT   = (DATA_W == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_shift;
    logic [PAT_W-1:0]     r_pat;
    logic                 r_sout;
    logic                 r_sout_valid;
    logic                 r_frame_done;
    logic                 r_data_ready;

    // Frame sequencer: every output is computed for the next cycle and
    // registered here, so sout/sout_valid/frame_done/data_ready are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_pat        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_data_ready <= 1'b1;
        end else if (abort) begin
            // Abort drops any frame in flight; in IDLE it also blocks accept.
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_data_ready <= 1'b1;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    r_data_ready <= 1'b1;
                    if (data_valid) begin
                        // Payload is captured here; later data_in changes
                        // cannot disturb the frame.
                        r_state      <= S_PRE;
                        r_cnt        <= c_PRE_LOAD;
                        r_shift      <= data_in;
                        r_sout       <= PATTERN[PAT_W-1];
                        r_pat        <= PATTERN << 1;
                        r_sout_valid <= 1'b1;
                        r_data_ready <= 1'b0;
                    end
                end

                S_PRE: begin
                    if (r_cnt == '0) begin
                        r_state      <= S_DATA;
                        r_cnt        <= c_DATA_LOAD;
                        r_sout       <= r_shift[DATA_W-1];
                        r_shift      <= r_shift << 1;
                        r_frame_done <= c_ONE_BIT;
                    end else begin
                        r_cnt        <= r_cnt - c_CNT_ONE;
                        r_sout       <= r_pat[PAT_W-1];
                        r_pat        <= r_pat << 1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        if (c_HAS_GAP) begin
                            r_state      <= S_GAP;
                            r_cnt        <= c_GAP_LOAD;
                            r_data_ready <= 1'b0;
                        end else begin
                            r_state      <= S_IDLE;
                            r_cnt        <= '0;
                            r_data_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt        <= r_cnt - c_CNT_ONE;
                        r_sout       <= r_shift[DATA_W-1];
                        r_shift      <= r_shift << 1;
                        // Next cycle carries payload[0] when one bit remains.
                        r_frame_done <= (r_cnt == c_CNT_ONE);
                    end
                end

                S_GAP: begin
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state      <= S_IDLE;
                        r_data_ready <= 1'b1;
                    end else begin
                        r_cnt        <= r_cnt - c_CNT_ONE;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    r_data_ready <= 1'b1;
                end
            endcase
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign frame_done = r_frame_done;
    assign data_ready = r_data_ready;

endmodule
`default_nettype wire
